// File: rtl/run_step_pkg.sv
// Shared types and default timing constants for the front-panel run/step controller.
package run_step_pkg;

  typedef enum logic [1:0] {
    HALT = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10,
    STOP = 2'b11
  } mode_t;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 32'h0004_0000;
  localparam int unsigned STEP_CYCLES_DEF     = 5;
  localparam int unsigned CNT_W_DEF           = 16;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer plus low-level run counter; emits one registered pulse per press.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_n_i,
  output logic evt_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          evt_q, evt_d;

  // Pulse only on the cycle the counter first lands on the threshold.
  always_comb begin
    cnt_d = cnt_q;
    if (sync_q[1]) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(DEBOUNCE_CYCLES)) begin
      cnt_d = cnt_q + CW'(1);
    end
    evt_d = (cnt_q != CW'(DEBOUNCE_CYCLES)) && (cnt_d == CW'(DEBOUNCE_CYCLES));
  end

  // Synchronizer resets to the released level so reset never looks like a press.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      evt_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_n_i};
      cnt_q  <= cnt_d;
      evt_q  <= evt_d;
    end
  end

  assign evt_o = evt_q;

endmodule

// File: rtl/run_step_controller.sv
// Front-panel execution controller: debounced run/step/halt buttons drive the pipeline enable.
// Optional breakpoint halt in RUN is enabled by defining BREAKPOINT_EN.
module run_step_controller
  import run_step_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned STEP_CYCLES     = STEP_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             btn_run_n,
  input  logic             btn_step_n,
  input  logic             btn_halt_n,
  input  logic             cpu_halted,
  input  logic [31:0]      pc,
`ifdef BREAKPOINT_EN
  input  logic [31:0]      bp_addr,
  input  logic             bp_valid,
  output logic             bp_hit,
`endif
  output logic             cpu_en,
  output logic [1:0]       mode,
  output logic [CNT_W-1:0] step_count
);

  localparam int unsigned SC_W = $clog2(STEP_CYCLES + 1);

  logic run_evt, step_evt, halt_evt;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .clock(clock), .reset(reset), .btn_n_i(btn_run_n), .evt_o(run_evt)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
    .clock(clock), .reset(reset), .btn_n_i(btn_step_n), .evt_o(step_evt)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_halt (
    .clock(clock), .reset(reset), .btn_n_i(btn_halt_n), .evt_o(halt_evt)
  );

  mode_t            state_q, state_d;
  logic [SC_W-1:0]  step_left_q, step_left_d;
  logic [CNT_W-1:0] step_count_q, step_count_d;
  logic             cpu_en_q, cpu_en_d;
  logic             bp_match_c;

`ifdef BREAKPOINT_EN
  logic first_run_q;
  logic bp_hit_q, bp_hit_d;

  // First RUN cycle is exempt so execution can resume from a breakpoint PC.
  assign bp_match_c = bp_valid && (pc == bp_addr) && !first_run_q;

  always_comb begin
    bp_hit_d = bp_hit_q;
    if ((state_q == RUN) && (state_d == HALT) && !halt_evt) begin
      bp_hit_d = 1'b1;
    end else if (run_evt || step_evt) begin
      bp_hit_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      first_run_q <= 1'b0;
      bp_hit_q    <= 1'b0;
    end else begin
      first_run_q <= (state_q != RUN) && (state_d == RUN);
      bp_hit_q    <= bp_hit_d;
    end
  end

  assign bp_hit = bp_hit_q;
`else
  logic unused_pc;
  assign unused_pc  = ^pc;
  assign bp_match_c = 1'b0;
`endif

  // Mode sequencing; cpu_halted outranks halt, and halt outranks step and run.
  always_comb begin
    state_d      = state_q;
    step_left_d  = step_left_q;
    step_count_d = step_count_q;
    case (state_q)
      HALT: begin
        if (halt_evt) begin
          state_d = HALT;
        end else if (step_evt) begin
          state_d     = STEP;
          step_left_d = SC_W'(STEP_CYCLES);
          if (step_count_q != {CNT_W{1'b1}}) begin
            step_count_d = step_count_q + CNT_W'(1);
          end
        end else if (run_evt) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (cpu_halted) begin
          state_d = STOP;
        end else if (halt_evt || bp_match_c) begin
          state_d = HALT;
        end
      end
      STEP: begin
        if (cpu_halted) begin
          state_d = STOP;
        end else if (halt_evt || (step_left_q == SC_W'(1))) begin
          state_d = HALT;
        end else begin
          step_left_d = step_left_q - SC_W'(1);
        end
      end
      default: state_d = STOP;
    endcase
    cpu_en_d = (state_d == RUN) || (state_d == STEP);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= HALT;
      step_left_q  <= '0;
      step_count_q <= '0;
      cpu_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_left_q  <= step_left_d;
      step_count_q <= step_count_d;
      cpu_en_q     <= cpu_en_d;
    end
  end

  assign cpu_en     = cpu_en_q;
  assign mode       = state_q;
  assign step_count = step_count_q;

endmodule
